sram_port_arbiter: RTL and testbench

- Shares a single-port external SRAM between the instruction-fetch stage and the data-memory stage of the ARM pipeline.
- Sequences each multi-cycle SRAM access through an FSM with a wait-state counter.
- Returns read data with a one-cycle ready pulse to the requester.
- Generates the freeze signals that stall the fetch stage and the whole pipeline while an access is outstanding.

---
 rtl/sram_port_arbiter_if.sv | 59 +++++
 rtl/sram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
//   Bundles the three buses that meet at the SRAM port arbiter:
//     - fetch port  : if_req, if_addr, if_rdata, if_ready
//     - data port   : mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
//                     mem_rdata, mem_ready
//     - SRAM port   : sram_addr, sram_wdata, sram_we, sram_oe, sram_rdata
//
//   Handshake: a requester raises its request (if_req, or mem_rd_en /
//   mem_wr_en) together with address/data and must hold all of them stable
//   until it sees the one-cycle ready pulse for its port; the request is
//   dropped on the cycle after that pulse. rdata is valid only while the
//   matching ready is high. A fetch whose address changes before completion
//   is treated as redirected and gets no ready pulse.
//
//   Modports:
//     slave  - the arbiter (takes requests, drives the SRAM)
//     master - the pipeline/SRAM side (used by the bench)
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ready;

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic                  sram_we;
    logic                  sram_oe;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        output sram_addr, sram_wdata, sram_we, sram_oe,
        input  sram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        input  sram_addr, sram_wdata, sram_we, sram_oe,
        output sram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one single-port SRAM between the fetch stage and the data-memory
//   stage. Each access runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE,
//   and the requester receives a one-cycle ready pulse in DONE, i.e.
//   WAIT_CYCLES+1 cycles after the request is accepted. The data port has
//   fixed priority (it belongs to the older instruction).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           sram_port_arbiter_if.slave (fetch, data and SRAM buses)
//   freeze_if     stall for fetch stage / PC (combinational)
//   freeze_pipe   stall for whole pipeline (combinational)
//   dbgState      current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//   if_stall_cycles / mem_stall_cycles
//                 saturating stall-cycle counters, present only when
//                 SRAM_ARB_STALL_CNT_EN is defined
//
// WAIT_CYCLES must be 1..15 (the wait counter is 4 bits).
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    sram_port_arbiter_if.slave bus,
    output logic        freeze_if,
    output logic        freeze_pipe,
    output logic [1:0]  dbgState
`ifdef SRAM_ARB_STALL_CNT_EN
    ,
    output logic [31:0] if_stall_cycles,
    output logic [31:0] mem_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t                state;
    logic   [3:0]          cnt;
    logic                  grantMem;   // 1 = data port, 0 = fetch port
    logic [ADDR_WIDTH-1:0] latAddr;
    logic [DATA_WIDTH-1:0] latWdata;
    logic                  latWrite;
    logic                  memReq;

    assign memReq = bus.mem_rd_en | bus.mem_wr_en;

    // The latched registers are the SRAM address/data outputs directly, so
    // they are registered and stay stable for the whole access.
    assign bus.sram_addr  = latAddr;
    assign bus.sram_wdata = latWdata;

    assign freeze_pipe = memReq & ~bus.mem_ready;
    assign freeze_if   = (bus.if_req & ~bus.if_ready) | freeze_pipe;
    assign dbgState    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            grantMem      <= 1'b0;
            latAddr       <= '0;
            latWdata      <= '0;
            latWrite      <= 1'b0;
            bus.sram_we   <= 1'b0;
            bus.sram_oe   <= 1'b0;
            bus.if_ready  <= 1'b0;
            bus.mem_ready <= 1'b0;
            bus.if_rdata  <= '0;
            bus.mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.if_ready  <= 1'b0;
                    bus.mem_ready <= 1'b0;
                    if (memReq || bus.if_req) begin
                        // Both enables high counts as a write.
                        grantMem    <= memReq;
                        latAddr     <= memReq ? bus.mem_addr : bus.if_addr;
                        latWdata    <= bus.mem_wdata;
                        latWrite    <= memReq & bus.mem_wr_en;
                        bus.sram_we <= memReq & bus.mem_wr_en;
                        bus.sram_oe <= ~(memReq & bus.mem_wr_en);
                        cnt         <= '0;
                        state       <= ACCESS;
                    end
                end

                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        bus.sram_we <= 1'b0;
                        bus.sram_oe <= 1'b0;
                        if (!latWrite) begin
                            if (grantMem) bus.mem_rdata <= bus.sram_rdata;
                            else          bus.if_rdata  <= bus.sram_rdata;
                        end
                        bus.mem_ready <= grantMem;
                        // A fetch whose address moved on was redirected;
                        // its data is dropped without a ready pulse.
                        bus.if_ready  <= ~grantMem & bus.if_req &
                                         (bus.if_addr == latAddr);
                        state         <= DONE;
                    end
                end

                DONE: begin
                    bus.if_ready  <= 1'b0;
                    bus.mem_ready <= 1'b0;
                    state         <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_ARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if_stall_cycles  <= '0;
            mem_stall_cycles <= '0;
        end else begin
            if (freeze_if && (if_stall_cycles != 32'hFFFF_FFFF))
                if_stall_cycles <= if_stall_cycles + 32'd1;
            if (freeze_pipe && (mem_stall_cycles != 32'hFFFF_FFFF))
                mem_stall_cycles <= mem_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter (WAIT_CYCLES=5). Each scenario
//   drives a request at the start of cycle t and records per-cycle output
//   bits (bit k = cycle t+k) sampled at the falling edge; the vectors are
//   compared with hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        freeze_if;
    logic        freeze_pipe;
    logic [1:0]  dbgState;
`ifdef SRAM_ARB_STALL_CNT_EN
    logic [31:0] if_stall_cycles;
    logic [31:0] mem_stall_cycles;
`endif

    sram_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    sram_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .freeze_if  (freeze_if),
        .freeze_pipe(freeze_pipe),
        .dbgState   (dbgState)
`ifdef SRAM_ARB_STALL_CNT_EN
        ,
        .if_stall_cycles (if_stall_cycles),
        .mem_stall_cycles(mem_stall_cycles)
`endif
    );

    // ---- clock / reset ---------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- SRAM model: fixed contents, data only while oe is high ----------
    function automatic logic [31:0] sramModel(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hE3A0_0005;
            32'h100: return 32'h1234_5678;
            default: return {a[15:0], 16'hC0DE};
        endcase
    endfunction

    assign bus.sram_rdata = bus.sram_oe ? sramModel(bus.sram_addr) : 32'h0;

    // ---- scoreboard ------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ[$];

    task automatic checkEq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---- window recorder -------------------------------------------------
    logic [15:0] oeV, weV, ifRdyV, memRdyV, frzIfV, frzPipeV;
    logic [31:0] weAddr, weData;
    logic        weSeen, weStable;

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles from the start of cycle t. Requests are dropped on the
    // cycle after their ready pulse; optionally the fetch address is
    // redirected at the start of cycle t+redirAt.
    task automatic runWindow(input int n, input int redirAt,
                             input logic [31:0] redirAddr);
        logic sawIf, sawMem, memIsRead;
        oeV = '0; weV = '0; ifRdyV = '0; memRdyV = '0;
        frzIfV = '0; frzPipeV = '0;
        weSeen = 1'b0; weStable = 1'b1; weAddr = '0; weData = '0;
        for (int k = 0; k < n; k++) begin
            if (k == redirAt) bus.if_addr = redirAddr;
            @(negedge clk);
            oeV[k]      = bus.sram_oe;
            weV[k]      = bus.sram_we;
            ifRdyV[k]   = bus.if_ready;
            memRdyV[k]  = bus.mem_ready;
            frzIfV[k]   = freeze_if;
            frzPipeV[k] = freeze_pipe;
            if (bus.sram_we) begin
                if (!weSeen) begin
                    weAddr = bus.sram_addr;
                    weData = bus.sram_wdata;
                    weSeen = 1'b1;
                end else if (bus.sram_addr !== weAddr ||
                             bus.sram_wdata !== weData) begin
                    weStable = 1'b0;
                end
            end
            sawIf     = bus.if_ready;
            sawMem    = bus.mem_ready;
            memIsRead = bus.mem_rd_en & ~bus.mem_wr_en;
            if (sawIf) begin
                checkEq("if_rdata_sb", bus.if_rdata,
                        (expQ.size() > 0) ? expQ.pop_front() : 32'hBAD0_0000);
            end
            if (sawMem && memIsRead) begin
                checkEq("mem_rdata_sb", bus.mem_rdata,
                        (expQ.size() > 0) ? expQ.pop_front() : 32'hBAD0_0000);
            end
            nextCycle();
            if (sawIf) bus.if_req = 1'b0;
            if (sawMem) begin
                bus.mem_rd_en = 1'b0;
                bus.mem_wr_en = 1'b0;
            end
        end
    endtask

    // ---- driver tasks ----------------------------------------------------
    task automatic driveIf(input logic [31:0] a);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
    endtask

    task automatic driveMem(input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
        bus.mem_rd_en = rd;
        bus.mem_wr_en = wr;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
    endtask

    // ---- stimulus --------------------------------------------------------
    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
        bus.mem_addr = '0; bus.mem_wdata = '0;
        repeat (3) nextCycle();

        // Reset state
        @(negedge clk);
        checkEq("rst_state",   dbgState, 2'd0);
        checkEq("rst_outputs", {bus.if_ready, bus.mem_ready, bus.sram_we,
                                bus.sram_oe, freeze_if, freeze_pipe}, 6'b0);
        checkEq("rst_addr",    bus.sram_addr, 32'h0);
        checkEq("rst_wdata",   bus.sram_wdata, 32'h0);
        checkEq("rst_rdata",   {bus.if_rdata, bus.mem_rdata}, 64'h0);
`ifdef SRAM_ARB_STALL_CNT_EN
        checkEq("rst_stall_cnt", {if_stall_cycles, mem_stall_cycles}, 64'h0);
`endif
        nextCycle();
        rst = 1'b0;
        nextCycle();

        // Reset in the middle of a write (cnt=2 during cycle t+3)
        driveMem(1'b0, 1'b1, 32'h300, 32'h1111_2222);
        repeat (3) nextCycle();
        @(negedge clk);
        checkEq("midrst_pre_we", {dbgState, bus.sram_we}, {2'd1, 1'b1});
        nextCycle();
        rst = 1'b1;
        driveMem(1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        checkEq("midrst_state", dbgState, 2'd0);
        checkEq("midrst_outs",  {bus.sram_we, bus.sram_oe, bus.if_ready,
                                 bus.mem_ready}, 4'b0);
        checkEq("midrst_addr",  bus.sram_addr, 32'h0);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        // IF read at 0x10
        expQ.push_back(32'hE3A0_0005);
        driveIf(32'h10);
        runWindow(7, -1, 32'h0);
        checkEq("ifrd_oe",     oeV,    16'h003E);
        checkEq("ifrd_we",     weV,    16'h0000);
        checkEq("ifrd_ready",  ifRdyV, 16'h0040);
        checkEq("ifrd_frz_if", frzIfV, 16'h003F);
        checkEq("ifrd_rdata",  bus.if_rdata, 32'hE3A0_0005);
        repeat (2) nextCycle();

        // Conflict: MEM read 0x100 wins, then IF 0x20
        expQ.push_back(32'h1234_5678);
        expQ.push_back(32'h0020_C0DE);
        driveIf(32'h20);
        driveMem(1'b1, 1'b0, 32'h100, 32'h0);
        runWindow(14, -1, 32'h0);
        checkEq("cfl_mem_ready", memRdyV,  16'h0040);
        checkEq("cfl_if_ready",  ifRdyV,   16'h2000);
        checkEq("cfl_oe",        oeV,      16'h1F3E);
        checkEq("cfl_frz_pipe",  frzPipeV, 16'h003F);
        checkEq("cfl_frz_if",    frzIfV,   16'h1FFF);
        checkEq("cfl_mem_rdata", bus.mem_rdata, 32'h1234_5678);
        repeat (2) nextCycle();

        // Write 0x104 <- DEADBEEF
        driveMem(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF);
        runWindow(7, -1, 32'h0);
        checkEq("wr_we",        weV,     16'h003E);
        checkEq("wr_oe",        oeV,     16'h0000);
        checkEq("wr_ready",     memRdyV, 16'h0040);
        checkEq("wr_bus",       {weStable, weAddr, weData},
                                {1'b1, 32'h104, 32'hDEAD_BEEF});
        checkEq("wr_rdata_kept", bus.mem_rdata, 32'h1234_5678);
        repeat (2) nextCycle();

        // Redirect: fetch 0x30 replaced by 0x80 at t+3
        expQ.push_back(32'h0080_C0DE);
        driveIf(32'h30);
        runWindow(14, 3, 32'h80);
        checkEq("redir_ready", ifRdyV, 16'h2000);
        checkEq("redir_oe",    oeV,    16'h1F3E);
        checkEq("redir_rdata", bus.if_rdata, 32'h0080_C0DE);
        repeat (2) nextCycle();

        // Both enables high: treated as a write
        driveMem(1'b1, 1'b1, 32'h200, 32'hA5A5_A5A5);
        runWindow(7, -1, 32'h0);
        checkEq("both_we",    weV,     16'h003E);
        checkEq("both_oe",    oeV,     16'h0000);
        checkEq("both_ready", memRdyV, 16'h0040);
        checkEq("both_bus",   {weStable, weAddr, weData},
                              {1'b1, 32'h200, 32'hA5A5_A5A5});
        checkEq("both_rdata_kept", bus.mem_rdata, 32'h1234_5678);
        repeat (2) nextCycle();

        @(negedge clk);
        checkEq("end_idle", dbgState, 2'd0);
        checkEq("sb_empty", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
